reg_wb_arbiter: RTL

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/reg_wb_arbiter.sv
// Two-requester round-robin write-back arbiter feeding one register-file write port,
// plus a per-register busy scoreboard (set at issue, cleared when the write lands).
module reg_wb_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_a_valid,
  input  logic [AW-1:0]    i_a_addr,
  input  logic [WIDTH-1:0] i_a_data,
  output logic             o_a_ready,
  input  logic             i_b_valid,
  input  logic [AW-1:0]    i_b_addr,
  input  logic [WIDTH-1:0] i_b_data,
  output logic             o_b_ready,
  input  logic             i_iss_valid,
  input  logic [AW-1:0]    i_iss_rd,
  output logic [DEPTH-1:0] o_busy,
  output logic [AW-1:0]    o_wr_addr,
  output logic [WIDTH-1:0] o_wr_data,
  output logic             o_wr_en
);

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } wb_req_t;

  logic             ptr;  // 0: A wins a tie, 1: B wins a tie
  logic             xfer;
  wb_req_t          sel;
  logic [DEPTH-1:0] set_vec, clr_vec, busy_nxt;

  always_comb begin
    o_a_ready = 1'b0;
    o_b_ready = 1'b0;
    if (!rst) begin
      o_a_ready = i_a_valid & (~i_b_valid | ~ptr);
      o_b_ready = i_b_valid & (~i_a_valid |  ptr);
    end
  end

  assign xfer = o_a_ready | o_b_ready;
  assign sel  = o_b_ready ? wb_req_t'{i_b_addr, i_b_data} : wb_req_t'{i_a_addr, i_a_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      // a tie always hands priority to the requester that just lost
      if (i_a_valid && i_b_valid) ptr <= ~ptr;
      o_wr_en <= xfer && (sel.addr != '0);
      if (xfer) begin
        o_wr_addr <= sel.addr;
        o_wr_data <= sel.data;
      end
    end
  end

  // Clear follows the registered write, so a same-edge issue to the same rd wins.
  always_comb begin
    set_vec     = i_iss_valid ? (DEPTH'(1) << i_iss_rd)  : '0;
    clr_vec     = o_wr_en     ? (DEPTH'(1) << o_wr_addr) : '0;
    busy_nxt    = (o_busy & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) o_busy <= '0;
    else     o_busy <= busy_nxt;
  end

endmodule
